// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
// Shared types and helpers for the serial adder.
//   state_t    : FSM state encoding (IDLE, RUN, DONE)
//   STATE_W    : width of the state encoding
//   cnt_width  : step-counter width for N digit steps, clog2(N) with a floor of 1
// Optional feature macro used by the design: SERIAL_ADDER_SUB_EN
package serial_adder_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single-step operation still needs a one-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if
// Handshake and operand/result bundle between the operand registers and the
// serial adder.
//   start, a, b, cin (and sub when SERIAL_ADDER_SUB_EN is defined) : master -> slave
//   busy, done, sum, cout, ovf                                      : slave -> master
// Optional feature macro: SERIAL_ADDER_SUB_EN adds the sub request bit.
interface serial_adder_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout, ovf
  );
`else
  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );
`endif

endinterface

// File: rtl/serial_adder_digit_adder.sv
// digit_adder
// Combinational DIGIT-bit ripple adder made of full-adder cells.
//   cin   : carry into bit 0
//   a, b  : digit operands
//   s     : digit sum
//   cout  : carry out of the digit MSB
//   c_msb : carry into the digit MSB (used for the signed-overflow flag)
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic             cin,
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  // One full-adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    return {(x & y) | (c & (x ^ y)), x ^ y ^ c};
  endfunction

  // Carry kept in a procedural variable so the chain is a single comb block
  // rather than a self-referencing vector.
  always_comb begin
    logic c;
    c     = cin;
    c_msb = cin;
    s     = '0;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) c_msb = c;
      {c, s[i]} = full_add(a[i], b[i], c);
    end
    cout = c;
  end

endmodule

// File: rtl/serial_adder.sv
// serial_adder
// Multi-cycle adder: sums two WIDTH-bit operands DIGIT bits per clock with a
// start/busy/done handshake, carry-in, carry-out and signed-overflow flag.
//   clk : clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : serial_adder_if slave modport (start, a, b, cin, busy, done, sum, cout, ovf)
// Optional feature macro: SERIAL_ADDER_SUB_EN -- adds bus.sub; sub=1 computes
// a + ~b + 1 (cin ignored), cout is then NOT borrow.
//
// state | meaning
// IDLE  | waiting for start; sum/cout/ovf hold the last result
// RUN   | one digit step per clock, N steps total
// DONE  | result valid, done pulses for this one cycle
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic     clk,
  input logic     rst,
  serial_adder_if.slave bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH < 2) begin : g_bad_width
    $error("serial_adder: WIDTH must be at least 2");
  end
  if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("serial_adder: DIGIT must divide WIDTH exactly");
  end

  state_t state, state_nxt;

  logic [WIDTH-1:0]       a_sh;
  logic [WIDTH-1:0]       b_sh;
  logic [WIDTH-1:0]       sum_r;
  logic                   carry;
  logic [CW-1:0]          cnt;
  logic                   cout_r;
  logic                   ovf_r;

  logic                   accept;
  logic                   last;
  logic [WIDTH-1:0]       b_cap;
  logic                   cin_cap;

  logic [DIGIT-1:0]       dig_s;
  logic                   dig_cout;
  logic                   dig_cmsb;
  logic [WIDTH+DIGIT-1:0] sum_cat;

  // Subtraction is folded in at capture time so the run loop is add-only.
`ifdef SERIAL_ADDER_SUB_EN
  always_comb begin
    b_cap   = bus.sub ? ~bus.b : bus.b;
    cin_cap = bus.sub | bus.cin;
  end
`else
  always_comb begin
    b_cap   = bus.b;
    cin_cap = bus.cin;
  end
`endif

  digit_adder #(
    .DIGIT (DIGIT)
  ) u_digit_adder (
    .cin   (carry),
    .a     (a_sh[DIGIT-1:0]),
    .b     (b_sh[DIGIT-1:0]),
    .s     (dig_s),
    .cout  (dig_cout),
    .c_msb (dig_cmsb)
  );

  // New digit enters at the top; after N steps digit 0 has reached bit 0.
  assign sum_cat = {dig_s, sum_r};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cnt == LAST) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (accept) begin
      a_sh  <= bus.a;
      b_sh  <= b_cap;
      carry <= cin_cap;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> DIGIT;
      b_sh  <= b_sh >> DIGIT;
      carry <= dig_cout;
      cnt   <= cnt + 1'b1;
      sum_r <= sum_cat[WIDTH+DIGIT-1:DIGIT];
      if (last) begin
        cout_r <= dig_cout;
        // On the last step the digit MSB is bit WIDTH-1 of the word.
        ovf_r  <= dig_cout ^ dig_cmsb;
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;
  assign bus.ovf  = ovf_r;

endmodule
